// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low request/grant handshake.
// A bounded hold counter lets waiting masters preempt, but only at bus-cycle boundaries.
module yutorina_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_,
  input  logic [3:0] as_,
  output logic [3:0] grnt_,
  output logic [1:0] owner,
  output logic       busy
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic [1:0] owner_reg, owner_next;
  logic [3:0] grnt_reg, grnt_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       busy_reg;

  logic [3:0] req;
  logic [1:0] cand_idx [4];
  logic [3:0] cand_req;
  logic       other_found, any_found, preempt;
  logic [1:0] other_idx, any_idx;

  assign req = ~req_;

  // Candidate slot gi holds master (last + gi + 1) mod 4; slot 3 is last itself.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = last_reg + 2'(gi + 1);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // In OWNED, last equals owner, so the first three slots are exactly the non-owners.
  always_comb begin
    other_found = 1'b0;
    other_idx   = last_reg;
    for (int i = 0; i < 3; i++) begin
      if (!other_found && cand_req[i]) begin
        other_found = 1'b1;
        other_idx   = cand_idx[i];
      end
    end
    any_found = other_found | cand_req[3];
    any_idx   = other_found ? other_idx : last_reg;
  end

  assign preempt = (HOLD_LIM != 8'd0) && (cnt_reg == HOLD_LIM) &&
                   as_[owner_reg] && other_found;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    grnt_next  = grnt_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        grnt_next = 4'b1111;
        if (any_found) begin
          state_next = OWNED;
          last_next  = any_idx;
          owner_next = any_idx;
          grnt_next  = ~(4'b0001 << any_idx);
          cnt_next   = 8'd0;
        end
      end
      OWNED: begin
        if (!req[owner_reg] || preempt) begin
          // Release takes priority over preemption; both hand over without an idle cycle.
          if (other_found) begin
            last_next  = other_idx;
            owner_next = other_idx;
            grnt_next  = ~(4'b0001 << other_idx);
          end else begin
            state_next = IDLE;
            grnt_next  = 4'b1111;
          end
          cnt_next = 8'd0;
        end else if (other_found && (cnt_reg < HOLD_LIM)) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grnt_next  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      last_reg  <= 2'd3;
      owner_reg <= 2'd0;
      grnt_reg  <= 4'b1111;
      cnt_reg   <= 8'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;
      grnt_reg  <= grnt_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= ~&grnt_next;
    end
  end

  assign grnt_ = grnt_reg;
  assign owner = owner_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Bench for yutorina_bus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the round-robin/hold-time rules.
module tb_yutorina_bus_arbiter;

  localparam int HM = 4;
  localparam int STARVE_LIMIT = 4 * (HM + 2);

  logic       clk;
  logic       rst;
  logic [3:0] req_;
  logic [3:0] as_;
  logic [3:0] grnt_;
  logic [1:0] owner;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_busy;
  int m_owner;
  int m_last;
  int m_wait;
  int pre_owner;
  bit pre_locked;

  yutorina_bus_arbiter #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_  (req_),
    .as_   (as_),
    .grnt_ (grnt_),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr_find(int lst, logic [3:0] rn, bit skip_self);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (lst + k) % 4;
      if (k == 4 && skip_self) return -1;
      if (rn[idx] == 1'b0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grnt();
    logic [3:0] e;
    e = 4'b1111;
    if (m_busy) e[m_owner] = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_wait  = 0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT is about to sample.
  task automatic model_step();
    int others;
    int g;
    pre_owner  = m_owner;
    pre_locked = m_busy && !req_[m_owner] && !as_[m_owner];
    if (!m_busy) begin
      g = rr_find(m_last, req_, 1'b0);
      if (g >= 0) begin
        m_busy = 1'b1; m_owner = g; m_last = g; m_wait = 0;
      end
    end else begin
      others = rr_find(m_last, req_, 1'b1);
      if (req_[m_owner] || (HM != 0 && m_wait == HM && as_[m_owner] && others >= 0)) begin
        if (others >= 0) begin
          m_owner = others; m_last = others;
        end else begin
          m_busy = 1'b0;
        end
        m_wait = 0;
      end else if (others >= 0 && m_wait < HM) begin
        m_wait = m_wait + 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_ = 4'b1111;
    as_  = 4'b1111;
    do_reset();
    n_checks++;
    if (grnt_ !== 4'b1111) begin
      n_errors++; $display("FAIL reset_grnt: got %b want 1111", grnt_);
    end
    n_checks++;
    if (owner !== 2'd0) begin
      n_errors++; $display("FAIL reset_owner: got %0d want 0", owner);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1111) begin
      n_errors++; $display("FAIL idle_no_req: got %b want 1111", grnt_);
    end
    $display("test_reset done");
  endtask

  task automatic test_handover();
    do_reset();
    req_ = 4'b1100;
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1110 || owner !== 2'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL first_grant: got grnt=%b owner=%0d busy=%b want 1110/0/1", grnt_, owner, busy);
    end
    req_ = 4'b1101;
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1101 || owner !== 2'd1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL direct_handover: got grnt=%b owner=%0d busy=%b want 1101/1/1", grnt_, owner, busy);
    end
    req_ = 4'b1111;
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1111 || owner !== 2'd1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL release_idle: got grnt=%b owner=%0d busy=%b want 1111/1/0", grnt_, owner, busy);
    end
    $display("test_handover done");
  endtask

  task automatic test_round_robin();
    logic [3:0] pat [5];
    int         want [5];
    pat[0] = 4'b0000; pat[1] = 4'b0001; pat[2] = 4'b0010; pat[3] = 4'b0100; pat[4] = 4'b1000;
    want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 3; want[4] = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_ = pat[i];
      cycle();
      n_checks++;
      if (owner !== 2'(want[i]) || grnt_ !== ~(4'b0001 << want[i])) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: got owner=%0d grnt=%b want owner=%0d", i, owner, grnt_, want[i]);
      end
    end
    do_reset();
    req_ = 4'b1011;
    cycle();
    req_ = 4'b1111;
    cycle();
    req_ = 4'b0000;
    cycle();
    n_checks++;
    if (owner !== 2'd3 || grnt_ !== 4'b0111) begin
      n_errors++;
      $display("FAIL rr_resume_after_2: got owner=%0d grnt=%b want 3/0111", owner, grnt_);
    end
    req_ = 4'b1111;
    cycle();
    $display("test_round_robin done");
  endtask

  task automatic test_preempt();
    do_reset();
    as_  = 4'b1111;
    req_ = 4'b1011;
    cycle();
    req_ = 4'b1010;
    for (int i = 1; i <= HM; i++) begin
      cycle();
      n_checks++;
      if (grnt_ !== 4'b1011) begin
        n_errors++; $display("FAIL preempt_hold[%0d]: got %b want 1011", i, grnt_);
      end
    end
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1110 || owner !== 2'd0) begin
      n_errors++; $display("FAIL preempt_move: got grnt=%b owner=%0d want 1110/0", grnt_, owner);
    end
    // Same again, but the owner is mid bus cycle: the grant must wait for as_.
    req_ = 4'b1111;
    do_reset();
    req_ = 4'b1011;
    cycle();
    as_  = 4'b1011;
    req_ = 4'b1010;
    for (int i = 1; i <= HM + 4; i++) begin
      cycle();
      n_checks++;
      if (grnt_ !== 4'b1011) begin
        n_errors++; $display("FAIL preempt_as_low[%0d]: got %b want 1011", i, grnt_);
      end
    end
    as_ = 4'b1111;
    cycle();
    n_checks++;
    if (grnt_ !== 4'b1110 || owner !== 2'd0) begin
      n_errors++; $display("FAIL preempt_after_as: got grnt=%b owner=%0d want 1110/0", grnt_, owner);
    end
    req_ = 4'b1111;
    cycle();
    $display("test_preempt done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_ = 4'b1101;
    as_  = 4'b1101;
    cycle();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (grnt_ !== 4'b1111 || busy !== 1'b0) begin
      n_errors++; $display("FAIL async_reset_drop: got grnt=%b busy=%b want 1111/0", grnt_, busy);
    end
    @(negedge clk);
    rst  = 1'b1;
    req_ = 4'b0111;
    as_  = 4'b1111;
    cycle();
    n_checks++;
    if (grnt_ !== 4'b0111 || owner !== 2'd3 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_grant: got grnt=%b owner=%0d busy=%b want 0111/3/1", grnt_, owner, busy);
    end
    req_ = 4'b1111;
    cycle();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int wait_cnt [4];
    do_reset();
    req_ = 4'b1111;
    as_  = 4'b1111;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 5000; c++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(3) == 0) req_[b] = ~req_[b];
          as_[b] = (p == 1) ? 1'b1 : 1'($urandom_range(1));
        end
        cycle();
        n_checks++;
        if (grnt_ !== exp_grnt() || busy !== m_busy || (m_busy && owner !== 2'(m_owner))) begin
          n_errors++;
          $display("FAIL rand_model[%0d.%0d]: got grnt=%b owner=%0d busy=%b want grnt=%b owner=%0d busy=%b",
                   p, c, grnt_, owner, busy, exp_grnt(), m_owner, m_busy);
        end
        n_checks++;
        if ($countones(~grnt_) > 1) begin
          n_errors++; $display("FAIL rand_onehot[%0d.%0d]: got %b want at most one low", p, c, grnt_);
        end
        if (pre_locked) begin
          n_checks++;
          if (grnt_ !== ~(4'b0001 << pre_owner)) begin
            n_errors++;
            $display("FAIL rand_as_lock[%0d.%0d]: got %b want owner %0d kept", p, c, grnt_, pre_owner);
          end
        end
        if (p == 1) begin
          for (int b = 0; b < 4; b++) begin
            if (req_[b] == 1'b0 && grnt_[b] == 1'b1) wait_cnt[b]++;
            else wait_cnt[b] = 0;
            if (wait_cnt[b] > STARVE_LIMIT) begin
              n_checks++;
              n_errors++;
              $display("FAIL rand_starve[%0d]: got wait %0d want <= %0d", b, wait_cnt[b], STARVE_LIMIT);
              wait_cnt[b] = 0;
            end
          end
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst  = 1'b0;
    req_ = 4'b1111;
    as_  = 4'b1111;
    model_reset();
    test_reset();
    test_handover();
    test_round_robin();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/yutorina_bus_arbiter.md
YUTORINA_BUS_ARBITER -- requirements
Module: yutorina_bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, meaning the cycle limit an owner may keep the bus while another master waits (0 disables preemption; legal range 0..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req_, input, 4, per-master bus request, active-low; index 0 = CPU i-bus, 1 = CPU d-bus, 2 and 3 = spare masters.
REQ-005 SHALL have port as_, input, 4, per-master address strobe, active-low; low means that master has a bus cycle in progress.
REQ-006 SHALL have port grnt_, output, 4, per-master grant, active-low, registered.
REQ-007 SHALL have port owner, output, 2, index of the current or most recent grantee, registered.
REQ-008 SHALL have port busy, output, 1, high while any grnt_ bit is low, registered.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and OWNED (exactly one grant).
REQ-010 SHALL drive at most one grnt_ bit low in every cycle.
REQ-011 SHALL keep a 2-bit last pointer; round-robin search order starts at last+1 mod 4 and wraps 3->0.
REQ-012 IDLE: when any req_ bit is sampled low, grant the first requester in search order at the same edge (grnt_ low the cycle after req_ is first sampled), set owner and last to that index, clear the hold counter, and enter OWNED.
REQ-013 IDLE with req_ = 4'b1111 SHALL stay IDLE with grnt_ = 4'b1111.
REQ-014 OWNED: the owner keeps its grant while its req_ is low, except when preempted per REQ-017.
REQ-015 OWNED, owner req_ sampled high, another req_ low: grant passes at that edge directly to the next requester in search order, with no idle cycle; last and owner update and the counter clears.
REQ-016 OWNED, owner req_ sampled high, no other request: grnt_ = 4'b1111 at that edge, FSM -> IDLE, owner holds its value.
REQ-017 Hold counter: 8-bit; increments each OWNED cycle in which a non-owner req_ is low; saturates at HOLD_MAX; clears on every grant change; holds when no other master is requesting.
REQ-018 Preemption: when HOLD_MAX != 0, counter == HOLD_MAX, and the owner's as_ is sampled high, the grant SHALL move to the next requester in search order at that edge.
REQ-019 SHALL never revoke a grant while the owner's as_ is low; preemption waits until as_ is sampled high.
REQ-020 Owner release and preemption in the same cycle SHALL be handled as a normal release (REQ-015/016).
REQ-021 SHALL ignore as_ from non-owners.
REQ-022 A master that deasserts req_ before it is granted SHALL NOT be granted.
REQ-023 busy SHALL equal the OR of the inverted grnt_ bits, taken from the registered grant state.

Reset
REQ-024 While rst is low: grnt_ = 4'b1111, owner = 0, busy = 0, FSM = IDLE, last = 3 (master 0 has first priority), counter = 0; takes effect asynchronously.
REQ-025 Reset asserted mid-ownership SHALL drop the grant immediately, without waiting for as_.
REQ-026 After rst deasserts, the first arbitration SHALL occur at the first rising clk edge.

Verification
REQ-027 After reset, req_ = 4'b1100 held -> next edge grnt_ = 4'b1110, owner = 0, busy = 1.
REQ-028 Owner 0 releases (req_ = 4'b1101), master 1 still requesting -> next edge grnt_ = 4'b1101, owner = 1, no cycle with grnt_ = 4'b1111.
REQ-029 Masters 0..3 all requesting, each releasing one cycle after its grant -> grant order 0,1,2,3,0 after reset; with last = 2, order resumes at 3.
REQ-030 HOLD_MAX = 4, master 2 owns with as_ high and req_ low, master 0 requests -> grant moves to 0 on the edge where the counter equals 4; with master 2's as_ low, the grant holds until as_ goes high.
REQ-031 rst pulsed low mid-OWNED -> grnt_ = 4'b1111 and busy = 0 before the next clk edge; after release with req_ = 4'b0111 -> grnt_ = 4'b0111, owner = 3.
REQ-032 Random req_/as_ for 10k cycles -> at most one grnt_ bit low, no preemption while the owner's as_ is low, and every requester that holds req_ low is granted within 4*(HOLD_MAX+2) cycles when owners stop at bus-cycle boundaries.
